// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch PC and selects sequential, branch, jump or
// jump-register successors, with optional delay-slot sequencing. Optional exception
// redirect (exc/exc_vector/epc) is built when PC_EXCEPTION_EN is defined.
module pc_unit #(
  parameter int          WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          DELAY_SLOT   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [15:0]      branch_offset,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_target,
`ifdef PC_EXCEPTION_EN
  input  logic             exc,
  input  logic [WIDTH-1:0] exc_vector,
  output logic [WIDTH-1:0] epc,
`endif
  output logic [WIDTH-1:0] pcout,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             redirect_pending
);

  typedef enum logic {RUN = 1'b0, PENDING = 1'b1} state_t;

  localparam logic [WIDTH-1:0] RV = WIDTH'(RESET_VECTOR);

  state_t                  r_state, w_state_nxt;
  logic [WIDTH-1:0]        r_pc, w_pc_nxt;
  logic [WIDTH-1:0]        r_pend, w_pend_nxt;
  logic [WIDTH-1:0]        w_pc_plus4, w_br_target, w_j_target, w_target;
  logic signed [WIDTH-1:0] w_br_off;
  logic                    w_req;
`ifdef PC_EXCEPTION_EN
  logic [WIDTH-1:0]        r_epc, w_epc_nxt;
`endif

  assign w_pc_plus4  = r_pc + {{(WIDTH-3){1'b0}}, 3'd4};
  assign w_br_off    = {{(WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};
  assign w_br_target = w_pc_plus4 + $unsigned(w_br_off);
  assign w_j_target  = {w_pc_plus4[WIDTH-1:28], jump_index, 2'b00};

  // Priority jr > jump > branch; losers in the same cycle are simply dropped.
  assign w_req    = jr | jump | branch_taken;
  assign w_target = jr ? jr_target : (jump ? w_j_target : w_br_target);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend;
`ifdef PC_EXCEPTION_EN
    w_epc_nxt   = r_epc;
    if (exc) begin
      w_pc_nxt    = exc_vector;
      w_epc_nxt   = (r_state == PENDING) ? r_pend : r_pc;
      w_pend_nxt  = '0;
      w_state_nxt = RUN;
    end else
`endif
    if (!stall) begin
      if (DELAY_SLOT == 0) begin
        w_pc_nxt    = w_req ? w_target : w_pc_plus4;
        w_state_nxt = RUN;
      end else begin
        case (r_state)
          RUN: begin
            w_pc_nxt = w_pc_plus4;
            if (w_req) begin
              w_pend_nxt  = w_target;
              w_state_nxt = PENDING;
            end
          end
          // Requests seen while the delay slot is in flight are ignored.
          PENDING: begin
            w_pc_nxt    = r_pend;
            w_state_nxt = RUN;
          end
          default: w_state_nxt = RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_pc    <= RV;
      r_pend  <= '0;
`ifdef PC_EXCEPTION_EN
      r_epc   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_pend  <= w_pend_nxt;
`ifdef PC_EXCEPTION_EN
      r_epc   <= w_epc_nxt;
`endif
    end
  end

  assign pcout            = r_pc;
  assign pc_plus4         = w_pc_plus4;
  assign redirect_pending = (r_state == PENDING);
`ifdef PC_EXCEPTION_EN
  assign epc              = r_epc;
`endif

endmodule
